// File: rtl/spi_cfg_receiver.sv
`default_nettype none
// ============================================================================
// Module : spi_cfg_receiver
// Oversampled SPI frame receiver; a shadowed frame is committed to cfg on a
// sample tick, and per-channel command bits auto-clear one tick later.
// Rev    : 1.0
// ============================================================================
module spi_cfg_receiver #(
  parameter int FRAME_BITS  = 1024,
  parameter int N_CHANNELS  = 8,
  parameter int CMD_OFFSET  = 64,
  parameter int CH_STRIDE   = 112,
  parameter int CLEAR_BIT   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  input  logic                  spi_csn,
  output logic                  spi_miso,
  input  logic                  sample_tick,
  output logic [FRAME_BITS-1:0] cfg,
  output logic                  cfg_update,
  output logic                  frame_err,
  output logic                  overrun
);

  generate
    if (CMD_OFFSET + (N_CHANNELS - 1) * CH_STRIDE + 7 >= FRAME_BITS) begin : g_bad_layout
      $error("spi_cfg_receiver: command bytes extend past FRAME_BITS");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("spi_cfg_receiver: SYNC_STAGES must be at least 2");
    end
  endgenerate

  localparam int c_cnt_w   = $clog2(FRAME_BITS + 2);
  localparam int c_flush_w = $clog2(SYNC_STAGES + 2);
  localparam logic [c_cnt_w-1:0]   c_cnt_full   = c_cnt_w'(FRAME_BITS);
  localparam logic [c_cnt_w-1:0]   c_cnt_sat    = c_cnt_w'(FRAME_BITS + 1);
  localparam logic [c_cnt_w-1:0]   c_cnt_one    = c_cnt_w'(1);
  localparam logic [c_flush_w-1:0] c_flush_done = c_flush_w'(SYNC_STAGES + 1);
  localparam logic [c_flush_w-1:0] c_flush_one  = c_flush_w'(1);

  function automatic logic [FRAME_BITS-1:0] f_clr_mask();
    logic [FRAME_BITS-1:0] m;
    m = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      m[CMD_OFFSET + c * CH_STRIDE + CLEAR_BIT] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [FRAME_BITS-1:0] c_clr_mask = f_clr_mask();

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECV    = 2'd1,
    S_PENDING = 2'd2,
    S_CLEAR   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_csn_sync;
  logic                   r_sclk_hist, r_mosi_hist, r_csn_hist;
  logic [c_flush_w-1:0]   r_flush_cnt;

  state_t                 r_state, r_ret_state;
  state_t                 w_state_nxt, w_ret_nxt;
  logic                   w_accept, w_reject, w_commit, w_clear, w_ovr_set;

  logic [FRAME_BITS-1:0]  r_shadow, r_pend, r_cfg;
  logic [c_cnt_w-1:0]     r_bit_cnt;
  logic [6:0]             r_err_cnt;
  logic [7:0]             r_tx_sr;
  logic                   r_overrun, r_cfg_update, r_frame_err, r_clr_pend;

  logic w_live, w_sclk_s, w_csn_s;
  logic w_sclk_rise, w_sclk_fall, w_csn_fall, w_csn_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_csn_sync  <= '1;
      r_sclk_hist <= 1'b0;
      r_mosi_hist <= 1'b0;
      r_csn_hist  <= 1'b1;
      r_flush_cnt <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], spi_csn};
      r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
      r_mosi_hist <= r_mosi_sync[SYNC_STAGES-1];
      r_csn_hist  <= r_csn_sync[SYNC_STAGES-1];
      if (r_flush_cnt != c_flush_done) r_flush_cnt <= r_flush_cnt + c_flush_one;
    end
  end

  // Edges are masked until the chain has flushed out its reset levels, so a
  // frame already in progress at reset release does not look like a csn fall.
  assign w_live      = (r_flush_cnt == c_flush_done);
  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_csn_s     = r_csn_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_live &  w_sclk_s & ~r_sclk_hist;
  assign w_sclk_fall = w_live & ~w_sclk_s &  r_sclk_hist;
  assign w_csn_fall  = w_live & ~w_csn_s  &  r_csn_hist;
  assign w_csn_rise  = w_live &  w_csn_s  & ~r_csn_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ret_state <= S_IDLE;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_state <= w_ret_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_commit    = (r_state == S_PENDING) && sample_tick && w_csn_s;
    w_clear     = sample_tick && r_clr_pend && !w_commit;
    case (r_state)
      S_IDLE: begin
        if (w_csn_fall) begin
          w_state_nxt = S_RECV;
          w_ret_nxt   = S_IDLE;
        end
      end
      S_RECV: begin
        if (w_clear && r_ret_state == S_CLEAR) w_ret_nxt = S_IDLE;
        if (w_csn_rise) begin
          if (r_bit_cnt == c_cnt_full) begin
            w_accept    = 1'b1;
            w_state_nxt = S_PENDING;
          end else begin
            w_reject    = 1'b1;
            w_state_nxt = w_ret_nxt;
          end
        end
      end
      S_PENDING: begin
        if (w_csn_fall) begin
          w_state_nxt = S_RECV;
          w_ret_nxt   = S_PENDING;
        end else if (w_commit) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (w_csn_fall) begin
          w_state_nxt = S_RECV;
          w_ret_nxt   = w_clear ? S_IDLE : S_CLEAR;
        end else if (w_clear) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_ovr_set = w_accept && (r_ret_state == S_PENDING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow     <= '0;
      r_pend       <= '0;
      r_cfg        <= '0;
      r_bit_cnt    <= '0;
      r_err_cnt    <= '0;
      r_tx_sr      <= '0;
      r_overrun    <= 1'b0;
      r_cfg_update <= 1'b0;
      r_frame_err  <= 1'b0;
      r_clr_pend   <= 1'b0;
    end else begin
      r_cfg_update <= w_commit;
      r_frame_err  <= w_reject;

      if (w_sclk_rise && !w_csn_s) r_shadow <= {r_mosi_hist, r_shadow[FRAME_BITS-1:1]};

      if (w_csn_fall) begin
        r_bit_cnt <= w_sclk_rise ? c_cnt_one : '0;
      end else if (w_sclk_rise && !w_csn_s && r_bit_cnt != c_cnt_sat) begin
        r_bit_cnt <= r_bit_cnt + c_cnt_one;
      end

      // The shadow keeps shifting during a new frame, so an accepted frame is
      // parked separately until the commit tick.
      if (w_accept) r_pend <= r_shadow;

      if (w_commit)     r_cfg <= r_pend;
      else if (w_clear) r_cfg <= r_cfg & ~c_clr_mask;

      if (w_commit)     r_clr_pend <= 1'b1;
      else if (w_clear) r_clr_pend <= 1'b0;

      if (w_reject && r_err_cnt != 7'h7f) r_err_cnt <= r_err_cnt + 7'd1;

      if (w_csn_fall) begin
        r_tx_sr   <= {r_err_cnt, r_overrun};
        r_overrun <= 1'b0;
      end else begin
        if (w_sclk_fall) r_tx_sr <= {1'b0, r_tx_sr[7:1]};
        if (w_ovr_set)   r_overrun <= 1'b1;
      end
    end
  end

  assign spi_miso   = r_tx_sr[0];
  assign cfg        = r_cfg;
  assign cfg_update = r_cfg_update;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for spi_cfg_receiver: transaction-level model of pending/commit/clear
// plus directed frames with literal expectations.
module tb_spi_cfg_receiver;
  localparam int FB  = 64;
  localparam int NCH = 4;
  localparam int OFF = 4;
  localparam int STR = 14;
  localparam int CB  = 0;
  localparam int SS  = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic spi_clk = 1'b0, spi_mosi = 1'b0, spi_csn = 1'b1, sample_tick = 1'b0;
  logic spi_miso, cfg_update, frame_err, overrun;
  logic [FB-1:0] cfg;

  int tests = 0, fails = 0;

  logic [FB-1:0] exp_cfg = '0, m_frame = '0;
  logic exp_upd = 1'b0, m_pend = 1'b0, m_clr = 1'b0, m_ovr = 1'b0;
  int   m_err = 0, exp_ferr = 0, ferr_seen = 0, upd_seen = 0;
  logic ferr_prev = 1'b0;

  spi_cfg_receiver #(
    .FRAME_BITS(FB), .N_CHANNELS(NCH), .CMD_OFFSET(OFF),
    .CH_STRIDE(STR), .CLEAR_BIT(CB), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_csn(spi_csn), .spi_miso(spi_miso), .sample_tick(sample_tick),
    .cfg(cfg), .cfg_update(cfg_update), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cfg", cfg, exp_cfg);
    check("cfg_update", {{(FB-1){1'b0}}, cfg_update}, {{(FB-1){1'b0}}, exp_upd});
    if (frame_err) begin
      check("frame_err_spacing", {{(FB-1){1'b0}}, ferr_prev}, '0);
      ferr_seen++;
    end
    if (cfg_update) upd_seen++;
    ferr_prev = frame_err;
  end

  task automatic model_reset();
    exp_cfg = '0; m_frame = '0; exp_upd = 1'b0;
    m_pend = 1'b0; m_clr = 1'b0; m_ovr = 1'b0; m_err = 0;
  endtask

  task automatic pulse_tick();
    @(negedge clk); sample_tick = 1'b1;
    @(posedge clk); #1; sample_tick = 1'b0;
    if (m_pend && spi_csn) begin
      exp_cfg = m_frame; m_pend = 1'b0; m_clr = 1'b1; exp_upd = 1'b1;
    end else if (m_clr) begin
      for (int c = 0; c < NCH; c++) exp_cfg[OFF + c * STR + CB] = 1'b0;
      m_clr = 1'b0;
    end
    @(posedge clk); #1; exp_upd = 1'b0;
  endtask

  task automatic send_frame(input logic [FB+1:0] data, input int nbits, input int tick_bit,
                            output logic [7:0] status);
    int r;
    logic [7:0] exp_st;
    r = $urandom_range(1, 8);
    @(negedge clk); #(r < 5 ? r : r + 1);
    spi_csn = 1'b0;
    exp_st  = {m_err[6:0], m_ovr};
    m_ovr   = 1'b0;
    status  = '0;
    #80;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = data[i];
      #40;
      if (i < 8) status[i] = spi_miso;
      spi_clk = 1'b1;
      if (i == tick_bit) fork pulse_tick(); join_none
      #40;
      spi_clk = 1'b0;
    end
    #40;
    spi_csn = 1'b1; spi_mosi = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    if (nbits == FB) begin
      if (m_pend) m_ovr = 1'b1;
      m_pend = 1'b1; m_frame = data[FB-1:0];
    end else begin
      m_err = (m_err == 127) ? 127 : m_err + 1;
      exp_ferr++;
    end
    check("status", {{(FB-8){1'b0}}, status}, {{(FB-8){1'b0}}, exp_st});
    check("overrun", {{(FB-1){1'b0}}, overrun}, {{(FB-1){1'b0}}, m_ovr});
    check("frame_err_count", FB'(ferr_seen), FB'(exp_ferr));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [FB+1:0] fa, fa2, fb_, fc, fd, fe, d;
    logic [7:0] st;
    int ferr_before;

    repeat (3) @(negedge clk);
    check("rst_cfg", cfg, '0);
    check("rst_cfg_update", {{(FB-1){1'b0}}, cfg_update}, '0);
    check("rst_frame_err", {{(FB-1){1'b0}}, frame_err}, '0);
    check("rst_overrun", {{(FB-1){1'b0}}, overrun}, '0);
    check("rst_miso", {{(FB-1){1'b0}}, spi_miso}, '0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single valid frame; channel 3 command byte = 0x05
    fa = {2'b00, 64'hA5A5_5A5A_F00F_3CC3};
    fa[OFF + 3 * STR +: 8] = 8'h05;
    send_frame(fa, FB, -1, st);
    check("t1_status", {{(FB-8){1'b0}}, st}, 64'h00);
    pulse_tick();
    check("t1_cfg", cfg, fa[FB-1:0]);
    check("t1_updates", FB'(upd_seen), 64'd1);
    repeat (4) @(negedge clk);
    pulse_tick();
    check("t1_ch3_cmd", {{(FB-8){1'b0}}, cfg[OFF + 3 * STR +: 8]}, 64'h04);

    // Short then long frame
    send_frame({$urandom, $urandom, 2'b01}, FB - 1, -1, st);
    send_frame({$urandom, $urandom, 2'b10}, FB + 1, -1, st);
    check("t2_ferr_pulses", FB'(ferr_seen), 64'd2);
    check("t2_no_update", FB'(upd_seen), 64'd1);

    // Overrun: A2 then B, single tick
    fa2 = {2'b00, 64'h0123_4567_89AB_CDEF};
    fb_ = {2'b00, 64'hFEDC_BA98_7654_3210};
    send_frame(fa2, FB, -1, st);
    check("t2_status", {{(FB-8){1'b0}}, st}, 64'h04);
    send_frame(fb_, FB, -1, st);
    pulse_tick();
    check("t4_cfg", cfg, fb_[FB-1:0]);
    check("t4_overrun", {{(FB-1){1'b0}}, overrun}, 64'd1);
    fc = {2'b00, 64'h1111_2222_3333_4444};
    send_frame(fc, FB, -1, st);
    check("t4_status", {{(FB-8){1'b0}}, st}, 64'h05);
    check("t4_overrun_cleared", {{(FB-1){1'b0}}, overrun}, 64'd0);

    // Tick while csn low must not commit
    fd = {2'b00, 64'hDEAD_BEEF_CAFE_F00D};
    send_frame(fd, FB, 30, st);
    check("t5_no_commit", FB'(upd_seen), 64'd2);
    pulse_tick();
    check("t5_cfg", cfg, fd[FB-1:0]);
    check("t5_updates", FB'(upd_seen), 64'd3);

    // Reset in the middle of a frame
    @(negedge clk); #3;
    spi_csn = 1'b0;
    #80;
    for (int i = 0; i < FB / 2; i++) begin
      spi_mosi = 1'($urandom); #40; spi_clk = 1'b1; #40; spi_clk = 1'b0;
    end
    @(negedge clk); #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_cfg_in_reset", cfg, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    spi_csn = 1'b1;
    repeat (10) @(negedge clk);
    ferr_before = ferr_seen;
    fe = {2'b00, 64'h5555_AAAA_0F0F_F0F0};
    send_frame(fe, FB, -1, st);
    pulse_tick();
    check("t6_cfg", cfg, fe[FB-1:0]);
    check("t6_no_ferr", FB'(ferr_seen), FB'(ferr_before));

    // Random phase, 100 frames at clk/8
    for (int n = 0; n < 100; n++) begin
      d = {2'b00, $urandom, $urandom};
      send_frame(d, FB, -1, st);
      pulse_tick();
      check("t7_cfg", cfg, d[FB-1:0]);
      if (n % 4 == 3) pulse_tick();
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
